// File: rtl/apb_reg_slave.sv
// APB slave with NUM_REGS read/write control registers plus a read-only status word.
// Define APB_REG_PSLVERR_EN to report out-of-range accesses and status writes on pslverr.
module apb_reg_slave #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 8,
   parameter int NUM_REGS    = 4,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                         pclk,
   input  logic                         preset_n,
   input  logic                         psel,
   input  logic                         penable,
   input  logic                         pwrite,
   input  logic [ADDR_W-1:0]            paddr,
   input  logic [DATA_W-1:0]            pwdata,
   input  logic [DATA_W-1:0]            status_in,
   output logic [DATA_W-1:0]            prdata,
   output logic                         pready,
   output logic                         pslverr,
   output logic [NUM_REGS*DATA_W-1:0]   reg_q,
   output logic [NUM_REGS-1:0]          wr_pulse
);

   localparam int IDX_W = ADDR_W - 2;
   localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                       state_q, state_d;
   logic [3:0]                   cnt_q, cnt_d;
   logic                         write_q, write_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [DATA_W-1:0]            prdata_q, prdata_d;
   logic [NUM_REGS*DATA_W-1:0]   regs_q, regs_d;
   logic [NUM_REGS-1:0]          wr_pulse_q, wr_pulse_d;

   logic [IDX_W-1:0]             paddr_idx;
   logic [1:0]                   unused_byte_offset;
   logic [DATA_W-1:0]            rd_word;
   logic                         pready_int;

   assign paddr_idx          = paddr[ADDR_W-1:2];
   assign unused_byte_offset = paddr[1:0];
   assign pready_int         = (state_q == ACCESS) && (cnt_q == 4'd0);

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (paddr_idx == IDX_W'(i)) rd_word = regs_q[i*DATA_W +: DATA_W];
      end
      if (paddr_idx == STATUS_IDX) rd_word = status_in;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      write_d    = write_q;
      idx_d      = idx_q;
      prdata_d   = prdata_q;
      regs_d     = regs_q;
      wr_pulse_d = '0;
      unique case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               state_d = ACCESS;
               cnt_d   = 4'(WAIT_CYCLES);
               write_d = pwrite;
               idx_d   = paddr_idx;
               if (!pwrite) prdata_d = rd_word;
            end
         end
         ACCESS: begin
            // Dropping psel abandons the transfer without side effects.
            if (!psel) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (penable) begin
               state_d = IDLE;
               if (write_q) begin
                  for (int i = 0; i < NUM_REGS; i++) begin
                     if (idx_q == IDX_W'(i)) begin
                        regs_d[i*DATA_W +: DATA_W] = pwdata;
                        wr_pulse_d[i]              = 1'b1;
                     end
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         write_q    <= 1'b0;
         idx_q      <= '0;
         prdata_q   <= '0;
         regs_q     <= '0;
         wr_pulse_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         write_q    <= write_d;
         idx_q      <= idx_d;
         prdata_q   <= prdata_d;
         regs_q     <= regs_d;
         wr_pulse_q <= wr_pulse_d;
      end
   end

`ifdef APB_REG_PSLVERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (state_q == IDLE && psel && !penable) begin
         err_d = (paddr_idx > STATUS_IDX) || (pwrite && (paddr_idx == STATUS_IDX));
      end
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) err_q <= 1'b0;
      else           err_q <= err_d;
   end

   assign pslverr = pready_int & err_q;
`else
   assign pslverr = 1'b0;
`endif

   assign prdata   = prdata_q;
   assign pready   = pready_int;
   assign reg_q    = regs_q;
   assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: two instances (0 and 3 wait states) checked against an array model.
// Expectations for pslverr follow APB_REG_PSLVERR_EN as seen by this bench.
module tb_apb_reg_slave;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int NR = 4;

   logic          pclk = 1'b0;
   logic          preset_n;
   logic          psel      [2];
   logic          penable   [2];
   logic          pwrite    [2];
   logic [AW-1:0] paddr     [2];
   logic [DW-1:0] pwdata    [2];
   logic [DW-1:0] status_in [2];
   logic [DW-1:0] prdata    [2];
   logic          pready    [2];
   logic          pslverr   [2];
   logic [NR*DW-1:0] reg_q  [2];
   logic [NR-1:0] wr_pulse  [2];

   int checks = 0;
   int errors = 0;

   // Reference state: register contents and last read word per instance.
   logic [DW-1:0] m_regs   [2][NR];
   logic [DW-1:0] m_prdata [2];
   int            waits    [2] = '{0, 3};

   always #5 pclk = ~pclk;

   apb_reg_slave #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .WAIT_CYCLES(0)) u_dut0 (
      .pclk(pclk), .preset_n(preset_n), .psel(psel[0]), .penable(penable[0]),
      .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .status_in(status_in[0]),
      .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]),
      .reg_q(reg_q[0]), .wr_pulse(wr_pulse[0]));

   apb_reg_slave #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .WAIT_CYCLES(3)) u_dut3 (
      .pclk(pclk), .preset_n(preset_n), .psel(psel[1]), .penable(penable[1]),
      .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .status_in(status_in[1]),
      .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]),
      .reg_q(reg_q[1]), .wr_pulse(wr_pulse[1]));

   task automatic checkOutput(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NR*DW-1:0] modelRegs(input int k);
      logic [NR*DW-1:0] v;
      for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_regs[k][i];
      return v;
   endfunction

   function automatic logic [DW-1:0] modelRead(input int k, input int idx, input logic [DW-1:0] st);
      if (idx < NR)  return m_regs[k][idx];
      if (idx == NR) return st;
      return '0;
   endfunction

   function automatic logic modelErr(input logic wr, input int idx);
`ifdef APB_REG_PSLVERR_EN
      return (idx > NR) || (wr && idx == NR);
`else
      return 1'b0;
`endif
   endfunction

   task automatic modelReset();
      for (int k = 0; k < 2; k++) begin
         m_prdata[k] = '0;
         for (int i = 0; i < NR; i++) m_regs[k][i] = '0;
      end
   endtask

   task automatic checkIdle(input int k, input string tag);
      checkOutput({tag, "_pready"},  pready[k],   '0);
      checkOutput({tag, "_pslverr"}, pslverr[k],  '0);
      checkOutput({tag, "_prdata"},  prdata[k],   m_prdata[k]);
      checkOutput({tag, "_reg_q"},   reg_q[k],    modelRegs(k));
      checkOutput({tag, "_wrpulse"}, wr_pulse[k], '0);
   endtask

   // One complete transfer; status_in switches to st_late right after the setup edge.
   task automatic applyStimulus(input int k, input logic wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data, input logic [DW-1:0] st,
                                input logic [DW-1:0] st_late);
      int idx = int'(addr[AW-1:2]);
      logic err = modelErr(wr, idx);
      logic [NR-1:0] exp_pulse = '0;
      psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
      paddr[k] = addr; pwdata[k] = data; status_in[k] = st;
      @(posedge pclk); #1;
      if (!wr) m_prdata[k] = modelRead(k, idx, st);
      status_in[k] = st_late;
      penable[k] = 1'b1;
      for (int n = 0; n <= waits[k]; n++) begin
         checkOutput("pready",  pready[k],  (n == waits[k]));
         checkOutput("pslverr", pslverr[k], (n == waits[k]) && err);
         checkOutput("prdata",  prdata[k],  m_prdata[k]);
         @(posedge pclk); #1;
      end
      psel[k] = 1'b0; penable[k] = 1'b0;
      if (wr && idx < NR) begin
         m_regs[k][idx] = data;
         exp_pulse[idx] = 1'b1;
      end
      checkOutput("wr_pulse", wr_pulse[k], exp_pulse);
      checkOutput("reg_q",    reg_q[k],    modelRegs(k));
      checkOutput("done_pready", pready[k], '0);
      @(posedge pclk); #1;
      checkOutput("pulse_end", wr_pulse[k], '0);
   endtask

   task automatic abortTransfer(input int k, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                input int nwait);
      psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = 1'b1;
      paddr[k] = addr; pwdata[k] = data;
      @(posedge pclk); #1;
      penable[k] = 1'b1;
      for (int n = 0; n < nwait; n++) begin
         checkOutput("abort_wait", pready[k], '0);
         @(posedge pclk); #1;
      end
      psel[k] = 1'b0; penable[k] = 1'b0;
      @(posedge pclk); #1;
      checkIdle(k, "abort");
   endtask

   initial begin
      preset_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
         paddr[k] = '0; pwdata[k] = '0; status_in[k] = '0;
      end
      modelReset();
      repeat (3) @(posedge pclk);
      #1;
      checkIdle(0, "rst0");
      checkIdle(1, "rst3");
      @(negedge pclk);
      preset_n = 1'b1;
      @(posedge pclk); #1;

      // Zero-wait write then read back of register 2.
      applyStimulus(0, 1'b1, 8'h08, 32'hDEADBEEF, 32'h0, 32'h0);
      checkOutput("reg2_value", reg_q[0][95:64], 32'hDEADBEEF);
      applyStimulus(0, 1'b0, 8'h08, 32'h0, 32'h0, 32'h0);
      checkOutput("read_back", prdata[0], 32'hDEADBEEF);

      // Status word reads, illegal status write, out-of-range read.
      applyStimulus(0, 1'b0, 8'h10, 32'h0, 32'h0000_00A5, 32'h0000_00A5);
      checkOutput("status_rd", prdata[0], 32'hA5);
      applyStimulus(0, 1'b1, 8'h10, 32'h1234, 32'h0000_00A5, 32'h0000_00A5);
      applyStimulus(0, 1'b0, 8'h20, 32'h0, 32'h0000_00A5, 32'h0000_00A5);
      checkOutput("oor_rd", prdata[0], 32'h0);

      // Wait-state instance: status changes after setup must not leak into prdata.
      applyStimulus(1, 1'b0, 8'h10, 32'h0, 32'h1111_2222, 32'h3333_4444);
      checkOutput("status_sampled", prdata[1], 32'h1111_2222);
      applyStimulus(1, 1'b1, 8'h00, 32'hCAFE_F00D, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 8'h00, 32'h0, 32'h0, 32'hFFFF_FFFF);
      applyStimulus(1, 1'b0, 8'h3C, 32'h0, 32'h0, 32'h0);

      // Abort after one wait cycle, then a normal transfer must still work.
      abortTransfer(1, 8'h04, 32'h55, 1);
      applyStimulus(1, 1'b1, 8'h04, 32'h66, 32'h0, 32'h0);

      // Reset during the second wait cycle of a write.
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
      paddr[1] = 8'h0C; pwdata[1] = 32'h7777_7777;
      @(posedge pclk); #1;
      penable[1] = 1'b1;
      @(posedge pclk); #1;
      preset_n = 1'b0;
      #1;
      modelReset();
      checkIdle(1, "midrst3");
      checkIdle(0, "midrst0");
      psel[1] = 1'b0; penable[1] = 1'b0;
      @(negedge pclk);
      preset_n = 1'b1;
      @(posedge pclk); #1;
      applyStimulus(1, 1'b1, 8'h0C, 32'h8888_0001, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 8'h0C, 32'h0, 32'h0, 32'h0);

      // Randomized traffic on both instances.
      for (int t = 0; t < 80; t++) begin
         int k = int'($urandom_range(0, 1));
         int idx = ($urandom_range(0, 9) == 0) ? 63 : int'($urandom_range(0, 6));
         logic [AW-1:0] addr = {6'(idx), 2'($urandom_range(0, 3))};
         applyStimulus(k, 1'($urandom_range(0, 1)), addr, $urandom, $urandom, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
